multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle RV32I control FSM.
- Sequences fetch/decode/execute/memory/writeback and produces the 4-bit ALU_control that the ALU consumes.
- Consumes the ALU's `zero` output as its branch-taken flag, closing the ALU interface from the issuing side.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- MEM_LAT, 0, extra wait cycles per memory access (0..7). A 3-bit wait counter stretches FETCH, MEMREAD and MEMWRITE.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU branch-condition flag (1 = take branch)
- pc_write  out  1  PC load strobe
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR/OldPC load strobe
- reg_write  out  1  register file write strobe
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J (combinational from op)
- ALU_control  out  4  ALU operation code
- illegal  out  1  unsupported instruction flag

Behaviour:
- **Structure.** Moore FSM. Outputs decode from state; ALU_control and imm_src additionally decode from op/funct3/funct7_5. Register state and the wait counter only.
- **Reset.** The asynchronous assert of rst_n forces state = FETCH, wait counter = 0, illegal = 0. While rst_n is low, pc_write, ir_write, mem_write and reg_write are forced to 0.
- **Wait states.** In FETCH, MEMREAD and MEMWRITE the FSM holds MEM_LAT extra cycles, counting 0..MEM_LAT. The strobes pc_write, ir_write and mem_write assert only in the final cycle of the state. The counter clears on every state exit.
- **States** (control values not listed are 0; ALU_control = ADD unless stated):
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1 -> DECODE.
  - DECODE: a=01, b=01, ADD (branch/JAL target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> illegal handling
  - MEMADR: a=10, b=01, ADD -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: result_src=00, adr_src=1 -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1 -> FETCH.
  - EXECUTER: a=10, b=00 -> ALUWB.
  - EXECUTEI: a=10, b=01 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - JAL: a=01, b=10, ADD, result_src=00, pc_write=1 -> ALUWB.
  - BRANCH: a=10, b=00, result_src=00, pc_write=zero -> FETCH.
- **ALU_control, R-type** (by funct3):
  - 000: ADD 0000, or SUB 0001 if funct7_5
  - 001: SLL 0101
  - 010: SLT 1001
  - 011: SLTU 1000
  - 100: XOR 0100
  - 101: SRL 0110, or SRA 0111 if funct7_5
  - 110: OR 0011
  - 111: AND 0010
- **ALU_control, I-type.** Same as R-type, except 000 is always ADD.
- **ALU_control, branch** (by funct3):
  - 000: BEQ 0001
  - 001: BNE 1010
  - 100: BLT 1001
  - 101: BGE 1100
  - 110: BLTU 1000
  - 111: BGEU 1011
  - 010/011: illegal
- **Illegal branch funct3.** Detected in DECODE and handled as an illegal instruction.
- **Sampling.** op/funct3/funct7_5 must remain stable from DECODE through the end of the instruction; the block does not latch them.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal instruction goes DECODE -> HALT. HALT is sticky; all strobes are 0 and illegal = 1 until rst_n is asserted.
- Undefined: an illegal instruction goes DECODE -> FETCH as a NOP. PC has already been advanced by 4. illegal pulses 1 for the DECODE cycle only.

Test Plan:
- MEM_LAT=0, lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); reg_write=1 with result_src=01 in cycle 5 only.
- R-type sub (funct3=000, funct7_5=1) -> ALU_control=0001 in EXECUTER; reg_write in ALUWB; 4 cycles total.
- beq, zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0. bgeu (funct3=111) -> ALU_control=1011.
- MEM_LAT=2, sw -> FETCH lasts 3 cycles with ir_write/pc_write only in the third; MEMWRITE lasts 3 cycles with mem_write only in the third.
- rst_n low during MEMWRITE wait -> all strobes 0 immediately; after release, state=FETCH with counter 0.
- op=1111111 -> with ILLEGAL_TRAP_EN: illegal stays 1 and no further strobes. Without it: illegal pulses for 1 cycle, then FETCH resumes.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM.
// Sequences fetch/decode/execute/memory/writeback for a shared-memory
// multicycle datapath and issues the 4-bit ALU operation code.
// MEM_LAT (0..7) stretches FETCH, MEMREAD and MEMWRITE by that many
// wait cycles; strobes fire only in the last cycle of those states.
// Optional feature macro: ILLEGAL_TRAP_EN. When defined, an illegal
// instruction parks the FSM in a sticky HALT state. When undefined,
// the instruction is dropped as a NOP and illegal pulses during DECODE.
// Inputs op/funct3/funct7_5 are not latched; the instruction register
// must hold them stable from DECODE to the end of the instruction.
// dbg_state mirrors the state register for observation.
module multicycle_control #(
    parameter int MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] ALU_control,
    output logic       illegal,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BRANCH, S_HALT
    } state_t;

    localparam logic [2:0] LP_LAT = MEM_LAT[2:0];
    localparam logic [3:0] ALU_ADD = 4'b0000;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_wait;
    logic [2:0] w_wait_next;
    logic       w_last;

    logic w_is_load, w_is_store, w_is_r, w_is_i, w_is_br, w_is_jal;
    logic w_legal;
    logic [3:0] w_alu_op;
    logic [3:0] w_alu_br;

    logic       w_pc_write, w_mem_write, w_ir_write, w_reg_write, w_illegal;
    logic       w_adr_src;
    logic [1:0] w_result_src, w_src_a, w_src_b;
    logic [3:0] w_alu_ctl;

    assign w_is_load  = (op == 7'b0000011);
    assign w_is_store = (op == 7'b0100011);
    assign w_is_r     = (op == 7'b0110011);
    assign w_is_i     = (op == 7'b0010011);
    assign w_is_br    = (op == 7'b1100011);
    assign w_is_jal   = (op == 7'b1101111);
    assign w_legal    = w_is_load | w_is_store | w_is_r | w_is_i | w_is_jal |
                        (w_is_br & (funct3 != 3'b010) & (funct3 != 3'b011));
    assign w_last     = (r_wait == LP_LAT);

    // State register and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
        end
    end

    // Immediate format select, straight from the opcode
    always_comb begin
        imm_src = 3'b000;
        if (w_is_store)    imm_src = 3'b001;
        else if (w_is_br)  imm_src = 3'b010;
        else if (w_is_jal) imm_src = 3'b011;
    end

    // Arithmetic ALU code; funct7_5 selects SUB only for R-type
    always_comb begin
        w_alu_op = ALU_ADD;
        case (funct3)
            3'b000: w_alu_op = (funct7_5 && w_is_r) ? 4'b0001 : 4'b0000;
            3'b001: w_alu_op = 4'b0101;
            3'b010: w_alu_op = 4'b1001;
            3'b011: w_alu_op = 4'b1000;
            3'b100: w_alu_op = 4'b0100;
            3'b101: w_alu_op = funct7_5 ? 4'b0111 : 4'b0110;
            3'b110: w_alu_op = 4'b0011;
            default: w_alu_op = 4'b0010;
        endcase
    end

    // Branch comparison ALU code
    always_comb begin
        w_alu_br = ALU_ADD;
        case (funct3)
            3'b000: w_alu_br = 4'b0001;
            3'b001: w_alu_br = 4'b1010;
            3'b100: w_alu_br = 4'b1001;
            3'b101: w_alu_br = 4'b1100;
            3'b110: w_alu_br = 4'b1000;
            3'b111: w_alu_br = 4'b1011;
            default: w_alu_br = ALU_ADD;
        endcase
    end

    // Next state, wait counter and Moore control outputs
    always_comb begin
        w_next       = r_state;
        w_wait_next  = 3'd0;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_alu_ctl    = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_src_b      = 2'b10;
                w_result_src = 2'b10;
                if (w_last) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_wait_next = r_wait + 3'd1;
                end
            end
            S_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b01;
                if (w_is_load || w_is_store) w_next = S_MEMADR;
                else if (w_is_r)             w_next = S_EXECUTER;
                else if (w_is_i)             w_next = S_EXECUTEI;
                else if (w_is_jal)           w_next = S_JAL;
                else if (w_legal)            w_next = S_BRANCH;
                else begin
                    w_illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    w_next    = S_HALT;
`else
                    w_next    = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
                w_next  = w_is_load ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (w_last) w_next = S_MEMWB;
                else        w_wait_next = r_wait + 3'd1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src = 1'b1;
                if (w_last) begin
                    w_mem_write = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    w_wait_next = r_wait + 3'd1;
                end
            end
            S_EXECUTER: begin
                w_src_a   = 2'b10;
                w_alu_ctl = w_alu_op;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_src_a   = 2'b10;
                w_src_b   = 2'b01;
                w_alu_ctl = w_alu_op;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_src_a    = 2'b01;
                w_src_b    = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BRANCH: begin
                w_src_a    = 2'b10;
                w_alu_ctl  = w_alu_br;
                w_pc_write = zero;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                w_illegal = 1'b1;
                w_next    = S_HALT;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts
    assign pc_write    = w_pc_write  & rst_n;
    assign ir_write    = w_ir_write  & rst_n;
    assign mem_write   = w_mem_write & rst_n;
    assign reg_write   = w_reg_write & rst_n;
    assign adr_src     = w_adr_src;
    assign result_src  = w_result_src;
    assign alu_src_a   = w_src_a;
    assign alu_src_b   = w_src_b;
    assign ALU_control = w_alu_ctl;
    assign illegal     = w_illegal;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances (MEM_LAT=0 and MEM_LAT=2)
// share the instruction inputs; the idle one is held in reset. For each
// instruction the reference model lists the expected per-cycle output
// vector by instruction class and latency, and the bench compares cycle
// by cycle. Handshake: none; the FSM is free-running, the bench holds
// op/funct3/funct7_5/zero stable for a whole instruction.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0;
  logic       rst2 = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  bit         sel = 1'b0;

  logic       pcw0, adr0, memw0, irw0, regw0, ill0;
  logic [1:0] rs0, a0, b0;
  logic [2:0] imm0;
  logic [3:0] alu0, dbg0;
  logic       pcw2, adr2, memw2, irw2, regw2, ill2;
  logic [1:0] rs2, a2, b2;
  logic [2:0] imm2;
  logic [3:0] alu2, dbg2;

  int n_total = 0;
  int n_pass  = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst0), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .pc_write(pcw0), .adr_src(adr0), .mem_write(memw0),
    .ir_write(irw0), .reg_write(regw0), .result_src(rs0), .alu_src_a(a0),
    .alu_src_b(b0), .imm_src(imm0), .ALU_control(alu0), .illegal(ill0),
    .dbg_state(dbg0)
  );

  multicycle_control #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst2), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .pc_write(pcw2), .adr_src(adr2), .mem_write(memw2),
    .ir_write(irw2), .reg_write(regw2), .result_src(rs2), .alu_src_a(a2),
    .alu_src_b(b2), .imm_src(imm2), .ALU_control(alu2), .illegal(ill2),
    .dbg_state(dbg2)
  );

  wire [18:0] obs0 = {pcw0, adr0, memw0, irw0, regw0, rs0, a0, b0, imm0, alu0, ill0};
  wire [18:0] obs2 = {pcw2, adr2, memw2, irw2, regw2, rs2, a2, b2, imm2, alu2, ill2};
  wire [18:0] obs  = sel ? obs2 : obs0;
  wire [3:0]  strb2 = {pcw2, irw2, memw2, regw2};

  // ---------------- reference model ----------------
  function automatic logic [18:0] vec(bit pcw, bit adr, bit memw, bit irw, bit regw,
                                      logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                      logic [2:0] imm, logic [3:0] alu, bit ill);
    return {pcw, adr, memw, irw, regw, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [3:0] alu_arith(logic [2:0] f3, logic f75, bit is_r);
    logic [3:0] tab [8];
    tab = '{4'b0000, 4'b0101, 4'b1001, 4'b1000, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
    if (f3 == 3'd0 && f75 && is_r) return 4'b0001;
    if (f3 == 3'd5 && f75) return 4'b0111;
    return tab[f3];
  endfunction

  function automatic logic [3:0] alu_branch(logic [2:0] f3);
    logic [3:0] tab [8];
    tab = '{4'b0001, 4'b1010, 4'b0000, 4'b0000, 4'b1001, 4'b1100, 4'b1000, 4'b1011};
    return tab[f3];
  endfunction

  function automatic bit legal(logic [6:0] o, logic [2:0] f3);
    if (o == 7'b1100011) return (f3 != 3'd2) && (f3 != 3'd3);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1101111);
  endfunction

  // Push the expected output vector for every cycle of one instruction
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                       input logic z, input int lat);
    logic [2:0] im;
    im = imm_of(o);
    for (int i = 0; i <= lat; i++)
      exp_q.push_back(vec(i == lat, 0, 0, i == lat, 0, 2'b10, 2'b00, 2'b10, im, 4'b0000, 0));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 4'b0000, !legal(o, f3)));
    if (!legal(o, f3)) begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++)
        exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 1));
`endif
    end else if (o == 7'b0000011) begin
      exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 4'b0000, 0));
      for (int i = 0; i <= lat; i++)
        exp_q.push_back(vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0));
      exp_q.push_back(vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 4'b0000, 0));
    end else if (o == 7'b0100011) begin
      exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 4'b0000, 0));
      for (int i = 0; i <= lat; i++)
        exp_q.push_back(vec(0, 1, i == lat, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0));
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == 7'b0010011) ? 2'b01 : 2'b00,
                          im, alu_arith(f3, f75, o == 7'b0110011), 0));
      exp_q.push_back(vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0));
    end else if (o == 7'b1101111) begin
      exp_q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 4'b0000, 0));
      exp_q.push_back(vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0));
    end else begin
      exp_q.push_back(vec(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, alu_branch(f3), 0));
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, got, want);
  endtask

  // ---------------- driver tasks ----------------
  // Hold both DUTs in reset, check the selected one, release it at a negedge
  task automatic do_reset(input bit s);
    rst0 = 1'b0;
    rst2 = 1'b0;
    sel  = s;
    op   = 7'b0110011;
    @(negedge clk);
    #1 check("reset_state", obs, vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 0));
    @(negedge clk);
    if (s) rst2 = 1'b1;
    else   rst0 = 1'b1;
  endtask

  // Run one instruction (or its first max_cyc cycles) starting at a negedge in FETCH
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                           input logic z, input int max_cyc);
    int n;
    op = o;
    funct3 = f3;
    funct7_5 = f75;
    zero = z;
    build(o, f3, f75, z, sel ? 2 : 0);
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      #1 check($sformatf("L%0d op%b f3%0d cyc%0d", sel ? 2 : 0, o, f3, n), obs, exp_q.pop_front());
      n++;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic run_random(input int count);
    logic [6:0] o;
    logic [2:0] f3;
    logic [6:0] ops [6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    for (int k = 0; k < count; k++) begin
      int kind;
      kind = $urandom_range(0, 6);
      f3 = 3'($urandom_range(0, 7));
      o = (kind == 6) ? 7'($urandom_range(0, 127)) : ops[kind];
`ifdef ILLEGAL_TRAP_EN
      if (!legal(o, f3)) begin
        o = 7'b0110011;
      end
`endif
      run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1000);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset(0);
    run_instr(7'b0000011, 3'd2, 0, 0, 1000);   // lw
    run_instr(7'b0110011, 3'd0, 1, 0, 1000);   // sub
    run_instr(7'b0010011, 3'd0, 1, 0, 1000);   // addi with bit30 set stays ADD
    run_instr(7'b0010011, 3'd5, 1, 0, 1000);   // srai
    run_instr(7'b1100011, 3'd0, 0, 1, 1000);   // beq taken
    run_instr(7'b1100011, 3'd0, 0, 0, 1000);   // beq not taken
    run_instr(7'b1100011, 3'd7, 0, 1, 1000);   // bgeu
    run_instr(7'b1101111, 3'd0, 0, 0, 1000);   // jal
    run_instr(7'b0100011, 3'd2, 0, 0, 1000);   // sw
`ifndef ILLEGAL_TRAP_EN
    run_instr(7'b1100011, 3'd2, 0, 0, 1000);   // branch funct3 010 is illegal
    run_instr(7'b0000011, 3'd2, 0, 0, 1000);
`endif
    run_random(30);

    do_reset(1);
    run_instr(7'b0100011, 3'd2, 0, 0, 1000);   // sw, MEM_LAT=2
    run_instr(7'b0000011, 3'd2, 0, 0, 1000);   // lw, MEM_LAT=2
    run_instr(7'b0100011, 3'd2, 0, 0, 6);      // stop inside the MEMWRITE wait
    #3 rst2 = 1'b0;
    #1 check("strobes_in_reset", {28'd0, strb2}, 32'd0);
    check("reset_mid_memwrite", obs, vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 4'b0000, 0));
    @(negedge clk);
    rst2 = 1'b1;
    run_instr(7'b0000011, 3'd2, 0, 0, 1000);   // full 3-cycle FETCH after reset
    run_random(15);

    run_instr(7'b1111111, 3'd0, 0, 0, 1000);   // unsupported opcode
`ifdef ILLEGAL_TRAP_EN
    do_reset(1);
`endif
    run_instr(7'b0110011, 3'd4, 0, 0, 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
